sprite_blitter: RTL

- Writer-side counterpart to the on-chip sprite ROMs: copies a rectangular 4-bit palette-index sprite from a sprite ROM read port into a framebuffer RAM write port at a given screen position.
- Sits between game logic (which issues blit commands) and the frame RAM scanned by the color mapper.
- Skips transparent pixels and clips to framebuffer bounds.
- Uses a start/busy/done handshake.

---
 rtl/sprite_blitter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
//
// Copies a rectangular sprite of 4-bit palette indices from a sprite ROM read
// port into a framebuffer RAM write port, placing its top-left pixel at
// (pos_x, pos_y). Pixels equal to TRANSPARENT are skipped. Pixels that land
// outside the FB_W x FB_H framebuffer are clipped: they are never written and
// never wrap into the next row. Clipping does not change the cycle count.
//
// Ports
//   i_Clk        system clock, all logic on the rising edge
//   i_Reset      synchronous active-high reset
//   i_start      blit request, only looked at while idle
//   i_pos_x/y    destination of sprite pixel (0,0)
//   i_spr_w/h    sprite size, 0..64 each (0 gives an empty blit)
//   i_spr_base   ROM address of sprite pixel (0,0), row-major, stride spr_w
//   o_rom_addr   sprite ROM read address (ROM answers one cycle later)
//   i_rom_data   sprite ROM read data
//   o_fb_addr    framebuffer write address (y*FB_W + x)
//   o_fb_data    framebuffer write data
//   o_fb_we      framebuffer write enable
//   o_busy       high while a blit is reading or draining
//   o_done       one-cycle pulse when a blit has finished
//
// Timing for a start accepted at edge k with N = w*h pixels: pixel i is read
// in cycle k+1+i and written in cycle k+3+i; done is high in cycle k+3+N.
// -----------------------------------------------------------------------------
module sprite_blitter #(
   parameter int         FB_W        = 400,
   parameter int         FB_H        = 400,
   parameter int         ADDR_W      = 19,
   parameter logic [3:0] TRANSPARENT = 4'h0
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic              i_start,
   input  logic [9:0]        i_pos_x,
   input  logic [9:0]        i_pos_y,
   input  logic [6:0]        i_spr_w,
   input  logic [6:0]        i_spr_h,
   input  logic [ADDR_W-1:0] i_spr_base,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [3:0]        i_rom_data,
   output logic [ADDR_W-1:0] o_fb_addr,
   output logic [3:0]        o_fb_data,
   output logic              o_fb_we,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [10:0]       FB_W_X = 11'(FB_W);
   localparam logic [10:0]       FB_H_Y = 11'(FB_H);
   localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Latched command
   logic [6:0]        r_w;
   logic [6:0]        r_h;
   logic [9:0]        r_pos_x;

   // Read-side walker: describes the pixel whose ROM address is on o_rom_addr
   logic [ADDR_W-1:0] r_rom_addr;
   logic [6:0]        r_col;
   logic [6:0]        r_row;
   logic [10:0]       r_x;
   logic [10:0]       r_y;
   logic [ADDR_W-1:0] r_row_start;
   logic              r_drain;

   // One stage of side information travelling alongside the ROM read
   logic              r_s1_valid;
   logic [10:0]       r_s1_x;
   logic [10:0]       r_s1_y;
   logic [ADDR_W-1:0] r_s1_addr;

   // Registered outputs
   logic              r_fb_we;
   logic [ADDR_W-1:0] r_fb_addr;
   logic [3:0]        r_fb_data;
   logic              r_busy;
   logic              r_done;

   logic              w_last;
   logic              w_zero;
   logic [ADDR_W-1:0] w_row_init;
   logic [ADDR_W-1:0] w_pp [ADDR_W];

   assign w_last = (r_col == r_w - 7'd1) && (r_row == r_h - 7'd1);
   assign w_zero = (i_spr_w == 7'd0) || (i_spr_h == 7'd0);

   // Starting row address pos_y*FB_W built as a sum of shifted copies of
   // pos_y, one per set bit of the constant FB_W. Subsequent rows just add
   // FB_W to the running row start.
   generate
      for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_pp
         if (((FB_W >> gi) & 1) != 0) begin : g_on
            assign w_pp[gi] = ADDR_W'(i_pos_y) << gi;
         end else begin : g_off
            assign w_pp[gi] = '0;
         end
      end
   endgenerate

   always_comb begin
      w_row_init = '0;
      for (int b = 0; b < ADDR_W; b++) begin
         w_row_init = w_row_init + w_pp[b];
      end
   end

   // State register
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_next = w_zero ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (w_last) begin
               w_state_next = S_DRAIN;
            end
         end
         // Two drain cycles cover the ROM latency and the output register.
         S_DRAIN: begin
            if (r_drain) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_w         <= '0;
         r_h         <= '0;
         r_pos_x     <= '0;
         r_rom_addr  <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_row_start <= '0;
         r_drain     <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_x      <= '0;
         r_s1_y      <= '0;
         r_s1_addr   <= '0;
         r_fb_we     <= 1'b0;
         r_fb_addr   <= '0;
         r_fb_data   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_busy <= (w_state_next == S_READ) || (w_state_next == S_DRAIN);
         r_done <= (w_state_next == S_DONE);

         case (r_state)
            S_IDLE: begin
               if (i_start && !w_zero) begin
                  r_w         <= i_spr_w;
                  r_h         <= i_spr_h;
                  r_pos_x     <= i_pos_x;
                  r_rom_addr  <= i_spr_base;
                  r_col       <= '0;
                  r_row       <= '0;
                  r_x         <= {1'b0, i_pos_x};
                  r_y         <= {1'b0, i_pos_y};
                  r_row_start <= w_row_init;
               end
            end
            S_READ: begin
               r_drain <= 1'b0;
               if (!w_last) begin
                  r_rom_addr <= r_rom_addr + 1'b1;
                  if (r_col == r_w - 7'd1) begin
                     r_col       <= '0;
                     r_row       <= r_row + 7'd1;
                     r_x         <= {1'b0, r_pos_x};
                     r_y         <= r_y + 11'd1;
                     r_row_start <= r_row_start + FB_W_A;
                  end else begin
                     r_col <= r_col + 7'd1;
                     r_x   <= r_x + 11'd1;
                  end
               end
            end
            S_DRAIN: r_drain <= 1'b1;
            default: ;
         endcase

         // Stage 1: tag the read just issued
         r_s1_valid <= (r_state == S_READ);
         r_s1_x     <= r_x;
         r_s1_y     <= r_y;
         r_s1_addr  <= r_row_start + ADDR_W'(r_x);

         // Stage 2: ROM data is now valid; decide whether to write. The
         // bounds test on the unwrapped 11-bit x/y is what prevents an
         // off-screen column from spilling into the next row.
         r_fb_we   <= r_s1_valid && (i_rom_data != TRANSPARENT) &&
                      (r_s1_x < FB_W_X) && (r_s1_y < FB_H_Y);
         r_fb_addr <= r_s1_addr;
         r_fb_data <= i_rom_data;
      end
   end

   assign o_rom_addr = r_rom_addr;
   assign o_fb_addr  = r_fb_addr;
   assign o_fb_data  = r_fb_data;
   assign o_fb_we    = r_fb_we;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule
